// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the data-memory port.
// Accepts one load/store per request handshake, computes the effective address
// (base + sign-extended offset), checks size, alignment and range, performs at
// most one memory access and returns the loaded value or a fault code.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         request handshake (ready only while idle)
//   req_store, req_size         operation and size code
//   req_base, req_offset        address operands (offset is a signed 12-bit value)
//   req_wdata                   store data
//   resp_valid/resp_ready       response handshake
//   resp_data, resp_fault,
//   resp_cause                  load result / fault code (01 misaligned, 10 range, 11 size)
//   mem_addr, mem_wr_data,
//   mem_we, mem_size            drive Data_memory
//   mem_rd_data                 combinational read data from Data_memory (already extended)
module load_store_unit #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned MEM_BYTES   = 1024,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_size,
    input  logic [31:0]       req_base,
    input  logic [11:0]       req_offset,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic              resp_fault,
    output logic [1:0]        resp_cause,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wr_data,
    output logic              mem_we,
    output logic [2:0]        mem_size,
    input  logic [31:0]       mem_rd_data
);

    localparam logic [2:0] MEM_BYTE_SIGNED       = 3'b000;
    localparam logic [2:0] MEM_HALFWORD_SIGNED   = 3'b001;
    localparam logic [2:0] MEM_WORD_SIGNED       = 3'b010;
    localparam logic [2:0] MEM_BYTE_UNSIGNED     = 3'b100;
    localparam logic [2:0] MEM_HALFWORD_UNSIGNED = 3'b101;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_ALIGN = 2'b01;
    localparam logic [1:0] CAUSE_RANGE = 2'b10;
    localparam logic [1:0] CAUSE_SIZE  = 2'b11;

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e              state_q, state_d;
    logic [31:0]         resp_data_q, resp_data_d;
    logic                resp_fault_q, resp_fault_d;
    logic [1:0]          resp_cause_q, resp_cause_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wr_data_q, mem_wr_data_d;
    logic                mem_we_q, mem_we_d;
    logic [2:0]          mem_size_q, mem_size_d;

    logic [31:0] ea;
    logic [1:0]  nbytes_m1;
    logic        size_ok;
    logic        misaligned;
    logic [32:0] last_byte;
    logic        out_of_range;
    logic [1:0]  cause;

    assign ea = req_base + {{20{req_offset[11]}}, req_offset};

    always_comb begin
        size_ok   = 1'b1;
        nbytes_m1 = 2'd0;
        case (req_size)
            MEM_BYTE_SIGNED, MEM_BYTE_UNSIGNED:         nbytes_m1 = 2'd0;
            MEM_HALFWORD_SIGNED, MEM_HALFWORD_UNSIGNED: nbytes_m1 = 2'd1;
            MEM_WORD_SIGNED:                            nbytes_m1 = 2'd3;
            default:                                    size_ok   = 1'b0;
        endcase
    end

    assign misaligned = CHECK_ALIGN &&
                        (((nbytes_m1 == 2'd1) && ea[0]) ||
                         ((nbytes_m1 == 2'd3) && (ea[1:0] != 2'b00)));

    // 33-bit sum so a wrap past 2^32 is caught as out of range.
    assign last_byte    = {1'b0, ea} + {31'b0, nbytes_m1};
    assign out_of_range = last_byte[32] || (last_byte[31:0] >= 32'(MEM_BYTES));

    always_comb begin
        if (!size_ok) begin
            cause = CAUSE_SIZE;
        end else if (misaligned) begin
            cause = CAUSE_ALIGN;
        end else if (out_of_range) begin
            cause = CAUSE_RANGE;
        end else begin
            cause = CAUSE_NONE;
        end
    end

    always_comb begin
        state_d       = state_q;
        resp_data_d   = resp_data_q;
        resp_fault_d  = resp_fault_q;
        resp_cause_d  = resp_cause_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        mem_we_d      = mem_we_q;
        mem_size_d    = mem_size_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (cause != CAUSE_NONE) begin
                        resp_fault_d = 1'b1;
                        resp_cause_d = cause;
                        resp_data_d  = 32'h0;
                        state_d      = StResp;
                    end else begin
                        resp_fault_d  = 1'b0;
                        resp_cause_d  = CAUSE_NONE;
                        mem_addr_d    = ea[ADDR_W-1:0];
                        mem_size_d    = req_size;
                        mem_wr_data_d = req_wdata;
                        mem_we_d      = req_store;
                        state_d       = StAccess;
                    end
                end
            end
            StAccess: begin
                mem_we_d    = 1'b0;
                // mem_we_q is still set here exactly when this access is a store.
                resp_data_d = mem_we_q ? 32'h0 : mem_rd_data;
                state_d     = StResp;
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            resp_data_q   <= 32'h0;
            resp_fault_q  <= 1'b0;
            resp_cause_q  <= CAUSE_NONE;
            mem_addr_q    <= '0;
            mem_wr_data_q <= 32'h0;
            mem_we_q      <= 1'b0;
            mem_size_q    <= MEM_WORD_SIGNED;
        end else begin
            state_q       <= state_d;
            resp_data_q   <= resp_data_d;
            resp_fault_q  <= resp_fault_d;
            resp_cause_q  <= resp_cause_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            mem_we_q      <= mem_we_d;
            mem_size_q    <= mem_size_d;
        end
    end

    assign req_ready   = (state_q == StIdle);
    assign resp_valid  = (state_q == StResp);
    assign resp_data   = resp_data_q;
    assign resp_fault  = resp_fault_q;
    assign resp_cause  = resp_cause_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_data = mem_wr_data_q;
    assign mem_we      = mem_we_q;
    assign mem_size    = mem_size_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a big-endian byte-array model of Data_memory.
module tb_load_store_unit;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_size = 3'b0;
    logic [31:0] req_base = 32'h0;
    logic [11:0] req_offset = 12'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic        resp_fault;
    logic [1:0]  resp_cause;
    logic [11:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic [31:0] mem_rd_data;

    int n_checks = 0;
    int n_bad    = 0;
    int we_cnt   = 0;

    logic [7:0] mem [4096];

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(12), .MEM_BYTES(1024), .CHECK_ALIGN(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_store   (req_store),
        .req_size    (req_size),
        .req_base    (req_base),
        .req_offset  (req_offset),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_fault  (resp_fault),
        .resp_cause  (resp_cause),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_we      (mem_we),
        .mem_size    (mem_size),
        .mem_rd_data (mem_rd_data)
    );

    // Data_memory model: sync write, cleared by reset, combinational extended read.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h0;
        end else if (mem_we) begin
            case (mem_size)
                LB, LBU: mem[mem_addr] <= mem_wr_data[7:0];
                LH, LHU: begin
                    mem[mem_addr]         <= mem_wr_data[15:8];
                    mem[mem_addr + 12'd1] <= mem_wr_data[7:0];
                end
                default: begin
                    mem[mem_addr]         <= mem_wr_data[31:24];
                    mem[mem_addr + 12'd1] <= mem_wr_data[23:16];
                    mem[mem_addr + 12'd2] <= mem_wr_data[15:8];
                    mem[mem_addr + 12'd3] <= mem_wr_data[7:0];
                end
            endcase
        end
    end

    always_comb begin
        mem_rd_data = 32'h0;
        case (mem_size)
            LB:  mem_rd_data = {{24{mem[mem_addr][7]}}, mem[mem_addr]};
            LBU: mem_rd_data = {24'h0, mem[mem_addr]};
            LH:  mem_rd_data = {{16{mem[mem_addr][7]}}, mem[mem_addr], mem[mem_addr + 12'd1]};
            LHU: mem_rd_data = {16'h0, mem[mem_addr], mem[mem_addr + 12'd1]};
            default: mem_rd_data = {mem[mem_addr], mem[mem_addr + 12'd1],
                                    mem[mem_addr + 12'd2], mem[mem_addr + 12'd3]};
        endcase
    end

    always @(posedge clk) begin
        if (mem_we) we_cnt <= we_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE (called just after a rising edge) and check
    // latency, memory-side outputs, the response and the write-enable count.
    task automatic run_req(input string tag, input bit store, input logic [2:0] size,
                           input logic [31:0] base, input logic [11:0] off,
                           input logic [31:0] wd, input logic [1:0] exp_cause,
                           input logic [31:0] exp_data);
        logic [31:0] ea;
        int          we0;
        ea  = base + {{20{off[11]}}, off};
        we0 = we_cnt;
        check_eq({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        req_store  = store;
        req_size   = size;
        req_base   = base;
        req_offset = off;
        req_wdata  = wd;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        if (exp_cause != 2'b00) begin
            check_eq({tag, ".f_valid"}, 32'(resp_valid), 32'd1);
            check_eq({tag, ".f_fault"}, 32'(resp_fault), 32'd1);
            check_eq({tag, ".f_cause"}, 32'(resp_cause), 32'(exp_cause));
            check_eq({tag, ".f_data"}, resp_data, 32'h0);
            check_eq({tag, ".f_we"}, 32'(mem_we), 32'd0);
        end else begin
            check_eq({tag, ".a_valid"}, 32'(resp_valid), 32'd0);
            check_eq({tag, ".a_ready"}, 32'(req_ready), 32'd0);
            check_eq({tag, ".a_we"}, 32'(mem_we), 32'(store));
            check_eq({tag, ".a_addr"}, 32'(mem_addr), 32'(ea[11:0]));
            check_eq({tag, ".a_size"}, 32'(mem_size), 32'(size));
            if (store) check_eq({tag, ".a_wdata"}, mem_wr_data, wd);
            tick();
            @(negedge clk);
            check_eq({tag, ".r_valid"}, 32'(resp_valid), 32'd1);
            check_eq({tag, ".r_fault"}, 32'(resp_fault), 32'd0);
            check_eq({tag, ".r_cause"}, 32'(resp_cause), 32'd0);
            check_eq({tag, ".r_data"}, resp_data, exp_data);
            check_eq({tag, ".r_we"}, 32'(mem_we), 32'd0);
        end
        tick();
        @(negedge clk);
        check_eq({tag, ".idle"}, 32'(req_ready), 32'd1);
        check_eq({tag, ".we_cycles"}, 32'(we_cnt - we0),
                 32'((store && exp_cause == 2'b00) ? 1 : 0));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst.req_ready", 32'(req_ready), 32'd1);
        check_eq("rst.resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst.resp_data", resp_data, 32'h0);
        check_eq("rst.resp_fault", 32'(resp_fault), 32'd0);
        check_eq("rst.resp_cause", 32'(resp_cause), 32'd0);
        check_eq("rst.mem_we", 32'(mem_we), 32'd0);
        check_eq("rst.mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst.mem_wr_data", mem_wr_data, 32'h0);
        check_eq("rst.mem_size", 32'(mem_size), 32'(LW));
        tick();

        run_req("sw_10", 1'b1, LW, 32'h10, 12'h000, 32'hDEADBEEF, 2'b00, 32'h0);
        run_req("lb_10", 1'b0, LB, 32'h10, 12'h000, 32'h0, 2'b00, 32'hFFFFFFDE);
        run_req("lhu_12", 1'b0, LHU, 32'h10, 12'h002, 32'h0, 2'b00, 32'h0000BEEF);
        run_req("lh_12", 1'b0, LH, 32'h14, 12'hFFE, 32'h0, 2'b00, 32'hFFFFBEEF);
        run_req("lw_10", 1'b0, LW, 32'h0, 12'h010, 32'h0, 2'b00, 32'hDEADBEEF);
        run_req("lw_mis", 1'b0, LW, 32'h10, 12'hFF1, 32'h0, 2'b01, 32'h0);
        run_req("sw_3fe", 1'b1, LW, 32'h3FE, 12'h000, 32'h12345678, 2'b01, 32'h0);
        run_req("sw_400", 1'b1, LW, 32'h400, 12'h000, 32'h12345678, 2'b10, 32'h0);
        run_req("lw_3fc0", 1'b0, LW, 32'h3FC, 12'h000, 32'h0, 2'b00, 32'h0);
        run_req("sb_3ff", 1'b1, LB, 32'h3FF, 12'h000, 32'hCAFE015A, 2'b00, 32'h0);
        run_req("lbu_3ff", 1'b0, LBU, 32'h400, 12'hFFF, 32'h0, 2'b00, 32'h0000005A);
        run_req("lw_3fc1", 1'b0, LW, 32'h3FC, 12'h000, 32'h0, 2'b00, 32'h0000005A);
        run_req("lh_3ff", 1'b0, LH, 32'h3FF, 12'h000, 32'h0, 2'b01, 32'h0);
        run_req("ill_sz", 1'b0, 3'b011, 32'h1, 12'h000, 32'h0, 2'b11, 32'h0);
        run_req("ill_sz7", 1'b1, 3'b111, 32'h20, 12'h000, 32'h0, 2'b11, 32'h0);
        run_req("lb_wrap", 1'b0, LB, 32'hFFFFFFFF, 12'h000, 32'h0, 2'b10, 32'h0);
        run_req("lw_wrap0", 1'b0, LW, 32'hFFFFFFFC, 12'h014, 32'h0, 2'b00, 32'hDEADBEEF);

        // Backpressure: response held for 3 cycles, second request waits for the handshake.
        resp_ready = 1'b0;
        req_store  = 1'b0;
        req_size   = LB;
        req_base   = 32'h10;
        req_offset = 12'h000;
        req_valid  = 1'b1;
        tick();
        req_size   = LHU;
        req_offset = 12'h002;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp.valid", 32'(resp_valid), 32'd1);
            check_eq("bp.data", resp_data, 32'hFFFFFFDE);
            check_eq("bp.req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check_eq("bp.valid_last", 32'(resp_valid), 32'd1);
        tick();
        @(negedge clk);
        check_eq("bp.idle_ready", 32'(req_ready), 32'd1);
        check_eq("bp.idle_valid", 32'(resp_valid), 32'd0);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("bp2.addr", 32'(mem_addr), 32'h12);
        check_eq("bp2.size", 32'(mem_size), 32'(LHU));
        check_eq("bp2.valid", 32'(resp_valid), 32'd0);
        tick();
        @(negedge clk);
        check_eq("bp2.rvalid", 32'(resp_valid), 32'd1);
        check_eq("bp2.data", resp_data, 32'h0000BEEF);
        tick();
        tick();

        // Reset asserted during the ACCESS cycle of a store.
        req_store  = 1'b1;
        req_size   = LW;
        req_base   = 32'h20;
        req_offset = 12'h000;
        req_wdata  = 32'h11223344;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check_eq("rsta.we", 32'(mem_we), 32'd1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("rsta.req_ready", 32'(req_ready), 32'd1);
        check_eq("rsta.resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rsta.mem_we", 32'(mem_we), 32'd0);
        tick();
        run_req("lw_20", 1'b0, LW, 32'h20, 12'h000, 32'h0, 2'b00, 32'h0);

        // Reset during RESP drops the response.
        resp_ready = 1'b0;
        req_store  = 1'b0;
        req_size   = LW;
        req_base   = 32'h1;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("rstr.valid", 32'(resp_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        check_eq("rstr.dropped", 32'(resp_valid), 32'd0);
        check_eq("rstr.fault", 32'(resp_fault), 32'd0);
        check_eq("rstr.cause", 32'(resp_cause), 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
